// File: rtl/font_rom_arbiter_if.sv
// Request, ROM and response bundle for the font ROM arbiter.
// slave = arbiter side; master = requesters, ROM model and response consumer.
interface font_rom_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 4,
    parameter int ID_W    = 3
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_ready;
    logic [ADDR_W-1:0]         rom_address;
    logic [DATA_W-1:0]         rom_q;
    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_data;
    logic                      busy;

    modport slave (
        input  req_valid, req_addr, rom_q,
        output req_ready, rom_address, rsp_valid, rsp_id, rsp_data, busy
    );

    modport master (
        output req_valid, req_addr, rom_q,
        input  req_ready, rom_address, rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

// File: rtl/font_rom_arbiter.sv
// Round-robin font ROM arbiter; FONT_ARB_PRIO0_EN gives requester 0 absolute priority.
// Response 2 cycles after accept, 1 accept/cycle; no backpressure on responses.
module font_rom_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 4,
    parameter int ID_W    = 3
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    font_rom_arbiter_if.slave  bus
);
    localparam int PW = $clog2(NUM_REQ);
`ifdef FONT_ARB_PRIO0_EN
    localparam bit PRIO0 = 1'b1;
`else
    localparam bit PRIO0 = 1'b0;
`endif

    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      gnt_idx;
    logic [NUM_REQ-1:0] gnt;
    logic               accept;
    logic [ADDR_W-1:0]  addr_q, gnt_addr;
    logic               s1_vld_q;
    logic [PW-1:0]      s1_id_q;
    logic               rsp_vld_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic [DATA_W-1:0]  rsp_data_q;

    // Grants are suppressed while reset is held so nothing is accepted into a cleared pipe.
    always_comb begin : arb
        int idx;
        logic [PW-1:0] cand;
        gnt     = '0;
        gnt_idx = '0;
        accept  = 1'b0;
        idx     = 0;
        cand    = '0;
        if (reset_n) begin
            if (PRIO0 && bus.req_valid[0]) begin
                accept = 1'b1;
                gnt[0] = 1'b1;
            end
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                cand = PW'(idx);
                if (!accept && bus.req_valid[cand] && !(PRIO0 && idx == 0)) begin
                    accept    = 1'b1;
                    gnt[cand] = 1'b1;
                    gnt_idx   = cand;
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept && !(PRIO0 && gnt_idx == '0))
            ptr_d = (gnt_idx == PW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
    end

    assign gnt_addr        = bus.req_addr[gnt_idx*ADDR_W +: ADDR_W];
    assign bus.req_ready   = gnt;
    // Registered fallback keeps the ROM address stable between grants.
    assign bus.rom_address = accept ? gnt_addr : addr_q;
    assign bus.rsp_valid   = rsp_vld_q;
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.busy        = s1_vld_q | rsp_vld_q;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q      <= '0;
            addr_q     <= '0;
            s1_vld_q   <= 1'b0;
            s1_id_q    <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            s1_vld_q  <= accept;
            rsp_vld_q <= s1_vld_q;
            if (accept) begin
                addr_q  <= gnt_addr;
                s1_id_q <= gnt_idx;
            end
            if (s1_vld_q) begin
                rsp_id_q   <= ID_W'(s1_id_q);
                rsp_data_q <= bus.rom_q;
            end
        end
    end
endmodule

// File: tb/tb_font_rom_arbiter.sv
// Scoreboard bench for font_rom_arbiter: directed phases then random traffic.
// A distance-based priority model predicts grants; a monitor checks tagged responses.
module tb_font_rom_arbiter;
    localparam int N  = 3;
    localparam int AW = 15;
    localparam int DW = 4;
    localparam int IW = 3;

    typedef struct {
        int           id;
        logic [DW-1:0] data;
        int           due;
    } exp_t;

    logic vga_clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 vga_clk = ~vga_clk;

    font_rom_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) bus();

    font_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [N-1:0]  v_req;
    logic [AW-1:0] a_req [N];
    exp_t          exp_q [$];
    int            n_chk  = 0;
    int            n_pass = 0;
    int            cyc    = 0;
    int            mp     = 0;
    logic [AW-1:0] last_a = '0;

    always_comb begin
        bus.req_valid = v_req;
        bus.req_addr  = '0;
        for (int i = 0; i < N; i++) bus.req_addr[i*AW +: AW] = a_req[i];
    end

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        if (a == 15'h0123) return 4'h5;
        return a[3:0] ^ a[7:4] ^ a[11:8] ^ {1'b0, a[14:12]} ^ 4'h9;
    endfunction

    always @(posedge vga_clk) bus.rom_q <= rom_word(bus.rom_address);
    always @(posedge vga_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    // Winner = valid requester with the smallest rotational distance from the pointer.
    task automatic eval_cycle(output int w);
        int best, d;
        logic [N-1:0]  exp_rdy;
        logic [AW-1:0] exp_addr;
        @(negedge vga_clk);
        w = -1;
        best = N;
`ifdef FONT_ARB_PRIO0_EN
        if (v_req[0]) w = 0;
        else
            for (int i = 1; i < N; i++)
                if (v_req[i]) begin
                    d = (i - mp + N) % N;
                    if (d < best) begin best = d; w = i; end
                end
`else
        for (int i = 0; i < N; i++)
            if (v_req[i]) begin
                d = (i - mp + N) % N;
                if (d < best) begin best = d; w = i; end
            end
`endif
        exp_rdy  = (w >= 0) ? (N'(1) << w) : '0;
        exp_addr = (w >= 0) ? a_req[w] : last_a;
        chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        chk("rom_address", 32'(bus.rom_address), 32'(exp_addr));
        if (w >= 0) begin
            exp_t e;
            e.id   = w;
            e.data = rom_word(a_req[w]);
            e.due  = cyc + 2;
            exp_q.push_back(e);
            last_a = a_req[w];
`ifdef FONT_ARB_PRIO0_EN
            if (w != 0) mp = (w + 1) % N;
`else
            mp = (w + 1) % N;
`endif
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge vga_clk);
            if (reset_n) begin
                logic exp_busy, exp_v;
                exp_busy = 1'b0;
                foreach (exp_q[i]) if (exp_q[i].due <= cyc + 1) exp_busy = 1'b1;
                chk("busy", 32'(bus.busy), 32'(exp_busy));
                exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
                chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_v));
                if (exp_v) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (bus.rsp_valid) begin
                        chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
                        chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin : driver
        int w;
        v_req    = '1;
        a_req[0] = 15'h0123;
        a_req[1] = 15'h0456;
        a_req[2] = 15'h0789;
        repeat (3) @(posedge vga_clk);
        #1;
        chk("reset_req_ready", 32'(bus.req_ready), 32'(0));
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'(0));
        chk("reset_rom_address", 32'(bus.rom_address), 32'(0));
        chk("reset_busy", 32'(bus.busy), 32'(0));
        chk("reset_rsp_id", 32'(bus.rsp_id), 32'(0));
        chk("reset_rsp_data", 32'(bus.rsp_data), 32'(0));
        reset_n = 1'b1;

        // All three contend continuously; first grant must be requester 0.
        eval_cycle(w);
        chk("first_grant", 32'(bus.req_ready), 32'(1));
        tick();
        repeat (5) begin eval_cycle(w); tick(); end

        // Lone read of the known word, then idle while it drains.
        v_req = 3'b001;
        eval_cycle(w);
        tick();
        v_req = '0;
        repeat (3) begin eval_cycle(w); tick(); end

        // Two-way contention.
        v_req = 3'b011;
        repeat (8) begin eval_cycle(w); tick(); end

        // Wrap from the top requester, then 1 vs 2, then idle address hold.
        v_req = 3'b100;
        eval_cycle(w); tick();
        v_req = 3'b110;
        eval_cycle(w); tick();
        v_req = '0;
        repeat (5) begin eval_cycle(w); tick(); end

        // Reset one cycle after accepting 0x7FFF.
        v_req    = 3'b001;
        a_req[0] = 15'h7FFF;
        eval_cycle(w);
        tick();
        reset_n = 1'b0;
        v_req   = '0;
        exp_q.delete();
        mp     = 0;
        last_a = '0;
        @(negedge vga_clk);
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
        chk("midrst_busy", 32'(bus.busy), 32'(0));
        chk("midrst_rom_address", 32'(bus.rom_address), 32'(0));
        tick();
        tick();
        reset_n = 1'b1;
        repeat (4) begin eval_cycle(w); tick(); end

        // Random traffic with withdrawals.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!v_req[i]) begin
                    if ($urandom_range(3) != 0) begin
                        v_req[i] = 1'b1;
                        a_req[i] = AW'($urandom);
                    end
                end else if ($urandom_range(9) == 0) begin
                    v_req[i] = 1'b0;
                end
            end
            eval_cycle(w);
            tick();
            if (w >= 0) v_req[w] = 1'b0;
        end

        v_req = '0;
        repeat (4) begin eval_cycle(w); tick(); end
        chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/font_rom_arbiter.md
Name: font_rom_arbiter

Overview:
- Shares the single synchronous font ROM (15-bit address, 4-bit palette-index data, 1-cycle read latency) between NUM_REQ text-rendering requesters, e.g. the pixel-path glyph fetcher and a score/message overlay.
- Accepts address requests with a valid/ready handshake and arbitrates round-robin, at most one grant per cycle.
- Drives the ROM address and returns each read as a tagged response pulse.
- Sits between the text renderers and the font_rom/font_palette pair on the VGA clock domain.

Parameters:
- NUM_REQ, 2: number of requesters; legal range 2..8.
- ADDR_W, 15: font ROM address width.
- DATA_W, 4: font ROM data width (palette index).
- ID_W, 3: response tag width; ID_W >= clog2(NUM_REQ).

Ports:
- vga_clk  in  1  sole clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- req_ready  out  NUM_REQ  one-hot-or-zero grant; combinational from req_valid and the priority pointer.
- rom_address  out  ADDR_W  to the ROM address input.
- rom_q  in  DATA_W  ROM read data, valid the cycle after the address is sampled.
- rsp_valid  out  1  registered response strobe.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_data  out  DATA_W  registered ROM data.
- busy  out  1  high while any read is in flight (stage 1 or stage 2 valid).

Behaviour:
- Reset (asynchronous assert, synchronous release): rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, the last-address register=0 (so rom_address=0), priority pointer=0, pipeline valid bits=0.
- Accept: requester i is accepted in cycle N when req_valid[i] && req_ready[i].
- Arbitration: scan starts at the priority pointer p, ascending and wrapping mod NUM_REQ. The first valid requester gets req_ready=1; all others get 0. With no valid requester, req_ready=0.
- Pointer update: on accept from i, p <= (i+1) mod NUM_REQ, so NUM_REQ-1 wraps to 0. With no accept, p holds.
- Address path:
  - In the accept cycle, rom_address is driven combinationally with the granted address.
  - In other cycles, rom_address holds the last granted address from a register, so the ROM input never toggles spuriously.
- Pipeline:
  - Stage 1 (the cycle after accept) captures valid and id.
  - In cycle N+1, the ROM presents data on rom_q.
  - At the end of N+1: rsp_data<=rom_q, rsp_id<=stage-1 id, rsp_valid<=stage-1 valid.
- Latency and throughput:
  - Response is visible in cycle N+2.
  - Full throughput: one accept per cycle; back-to-back responses in consecutive cycles stay in order.
- No backpressure: consumers must capture a response in its rsp_valid cycle. rsp_valid is a single-cycle pulse per accept.
- Requester rules:
  - A requester must hold req_valid and req_addr stable until accepted.
  - Dropping req_valid before accept is legal and simply withdraws the request.
- Reset mid-operation: in-flight reads are discarded, and no rsp_valid may appear after reset deasserts for reads accepted before reset.
- Width rules:
  - rsp_id is the zero-extended requester index.
  - Addresses pass through unmodified; there is no bounds check, and addresses >= ROM depth read whatever the ROM returns.

Optional Feature:
- Macro: FONT_ARB_PRIO0_EN.
- Defined:
  - Requester 0 (the live pixel fetch) wins whenever req_valid[0]=1, regardless of p.
  - Requesters 1..NUM_REQ-1 arbitrate round-robin among themselves only when req_valid[0]=0.
  - The pointer advances only on grants to requesters other than 0.
- Undefined: pure round-robin across all requesters, as described in Behaviour.

Test Plan:
- Reset check: hold reset_n=0 with requests asserted -> req_ready=0, rsp_valid=0, rom_address=0, busy=0; release reset -> the first grant goes to requester 0.
- Single read: req0 addr 0x0123 (ROM word = 0x5) accepted in cycle 10 -> rom_address=0x0123 in cycle 10; rsp_valid=1, rsp_id=0, rsp_data=0x5 in cycle 12 only.
- Round-robin contention: NUM_REQ=2, both valid continuously from reset -> grants alternate 0,1,0,1; responses return ids 0,1,0,1 on consecutive cycles with matching data.
- Wrap and idle: NUM_REQ=3, only req2 valid once -> p becomes 0. Then req1 and req2 valid together -> req1 wins. With no requests, rom_address holds the last address for 5 cycles.
- Reset mid-flight: assert reset_n=0 one cycle after accepting 0x7FFF -> no rsp_valid after reset deasserts; busy=0.
- FONT_ARB_PRIO0_EN: req0 valid continuously, req1 valid -> req1 never granted. When req0 drops, req1 is granted in the next evaluated cycle.
